mult_div_unit: RTL

MULT_DIV_UNIT -- requirements
Module: mult_div_unit

---
 rtl/mult_div_unit_pkg.sv | 35 +++
 rtl/mult_div_unit_if.sv | 24 ++
 rtl/mult_div_unit_div_iter.sv | 77 +++++++
 rtl/mult_div_unit.sv | 141 ++++++++++++++
 4 files changed

// File: rtl/mult_div_unit_pkg.sv
// Shared CPU package: ALU and HI/LO unit op codes.
// Also carries the default divide iteration count.
package mult_div_unit_pkg;

  typedef enum logic [3:0] {
    ALU_ADD, ALU_SUB, ALU_AND, ALU_OR,
    ALU_XOR, ALU_NOR, ALU_SLT, ALU_SLTU,
    ALU_SLL, ALU_SRL, ALU_SRA, ALU_LUI
  } alu_op_t;

  typedef enum logic [2:0] {
    MD_MULT  = 3'd0,
    MD_MULTU = 3'd1,
    MD_DIV   = 3'd2,
    MD_DIVU  = 3'd3,
    MD_MTHI  = 3'd4,
    MD_MTLO  = 3'd5
  } md_op_t;

  typedef enum logic [1:0] {
    DS_IDLE,
    DS_DIVIDE,
    DS_FINISH
  } div_state_t;

  localparam int DIV_CYCLES_DEF = 32;

  function automatic logic [31:0] cond_neg(
    input logic        neg,
    input logic [31:0] v
  );
    return neg ? (~v + 32'd1) : v;
  endfunction

endpackage

// File: rtl/mult_div_unit_if.sv
// Execute-stage <-> HI/LO unit bundle.
// master = CPU execute stage, slave = mult_div_unit.
interface mult_div_unit_if;

  logic        start;
  logic [2:0]  op;
  logic [31:0] a;
  logic [31:0] b;
  logic        busy;
  logic        done;
  logic [31:0] hi;
  logic [31:0] lo;

  modport master (
    output start, op, a, b,
    input  busy, done, hi, lo
  );

  modport slave (
    input  start, op, a, b,
    output busy, done, hi, lo
  );

endinterface

// File: rtl/mult_div_unit_div_iter.sv
// Restoring shift-subtract divider datapath.
// Works on magnitudes; signs are reapplied on the outputs.
module mult_div_unit_div_iter
  import mult_div_unit_pkg::*;
#(
  parameter int DIV_CYCLES = DIV_CYCLES_DEF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        en,
  input  logic        load,
  input  logic        step,
  input  logic        sgn,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic        last,
  output logic [31:0] quo_o,
  output logic [31:0] rem_o
);

  localparam int CW = $clog2(DIV_CYCLES) + 1;

  logic [CW-1:0] cnt;
  logic [31:0]   rem;
  logic [31:0]   quo;
  logic [31:0]   dvs;
  logic [31:0]   a_raw;
  logic          neg_q;
  logic          neg_r;
  logic          dbz;
  logic [32:0]   trial;
  logic [32:0]   diff;

  // quo doubles as the dividend shift register
  assign trial = {rem, quo[31]};
  assign diff  = trial - {1'b0, dvs};
  assign last  = (cnt == CW'(DIV_CYCLES - 1));

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt   <= '0;
      rem   <= '0;
      quo   <= '0;
      dvs   <= '0;
      a_raw <= '0;
      neg_q <= 1'b0;
      neg_r <= 1'b0;
      dbz   <= 1'b0;
    end else if (en) begin
      if (load) begin
        cnt   <= '0;
        rem   <= '0;
        quo   <= cond_neg(sgn && a[31], a);
        dvs   <= cond_neg(sgn && b[31], b);
        a_raw <= a;
        neg_q <= sgn && (a[31] ^ b[31]);
        neg_r <= sgn && a[31];
        dbz   <= (b == 32'd0);
      end else if (step) begin
        cnt <= cnt + 1'b1;
        if (!diff[32]) begin
          rem <= diff[31:0];
          quo <= {quo[30:0], 1'b1};
        end else begin
          rem <= trial[31:0];
          quo <= {quo[30:0], 1'b0};
        end
      end
    end
  end

  assign quo_o = dbz ? 32'hFFFF_FFFF
                     : cond_neg(neg_q, quo);
  assign rem_o = dbz ? a_raw
                     : cond_neg(neg_r, rem);

endmodule

// File: rtl/mult_div_unit.sv
// HI/LO multiply-divide unit: single-cycle multiply,
// iterative divide, MTHI/MTLO writes.
module mult_div_unit
  import mult_div_unit_pkg::*;
#(
  parameter int DIV_CYCLES = DIV_CYCLES_DEF
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           clk_enable,
  mult_div_unit_if.slave md
);

  div_state_t  state;
  div_state_t  state_n;
  logic        accept;
  logic        is_mul;
  logic        is_mulu;
  logic        is_div;
  logic        is_divu;
  logic        is_mthi;
  logic        is_mtlo;
  logic        load;
  logic        step;
  logic        finish;
  logic        last;
  logic [31:0] quo;
  logic [31:0] rem;
  logic [31:0] hi_q;
  logic [31:0] lo_q;
  logic        done_q;
  logic [63:0] prod_s;
  logic [63:0] prod_u;

  assign accept = md.start && (state == DS_IDLE);

  always_comb begin
    is_mul  = 1'b0;
    is_mulu = 1'b0;
    is_div  = 1'b0;
    is_divu = 1'b0;
    is_mthi = 1'b0;
    is_mtlo = 1'b0;
    unique case (1'b1)
      md.op == MD_MULT:  is_mul  = 1'b1;
      md.op == MD_MULTU: is_mulu = 1'b1;
      md.op == MD_DIV:   is_div  = 1'b1;
      md.op == MD_DIVU:  is_divu = 1'b1;
      md.op == MD_MTHI:  is_mthi = 1'b1;
      md.op == MD_MTLO:  is_mtlo = 1'b1;
      default: ;
    endcase
  end

  assign prod_s = $signed({{32{md.a[31]}}, md.a})
                * $signed({{32{md.b[31]}}, md.b});
  assign prod_u = {32'd0, md.a} * {32'd0, md.b};

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= DS_IDLE;
    end else if (clk_enable) begin
      state <= state_n;
    end
  end

  always_comb begin
    state_n = state;
    load    = 1'b0;
    step    = 1'b0;
    finish  = 1'b0;
    unique case (state)
      DS_IDLE: begin
        if (accept && (is_div || is_divu)) begin
          load    = 1'b1;
          state_n = DS_DIVIDE;
        end
      end
      DS_DIVIDE: begin
        step = 1'b1;
        if (last) state_n = DS_FINISH;
      end
      DS_FINISH: begin
        finish  = 1'b1;
        state_n = DS_IDLE;
      end
      default: state_n = DS_IDLE;
    endcase
  end

  mult_div_unit_div_iter #(
    .DIV_CYCLES(DIV_CYCLES)
  ) div_iter (
    .clk   (clk),
    .reset (reset),
    .en    (clk_enable),
    .load  (load),
    .step  (step),
    .sgn   (is_div),
    .a     (md.a),
    .b     (md.b),
    .last  (last),
    .quo_o (quo),
    .rem_o (rem)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      hi_q   <= '0;
      lo_q   <= '0;
      done_q <= 1'b0;
    end else if (clk_enable) begin
      done_q <= 1'b0;
      if (finish) begin
        hi_q   <= rem;
        lo_q   <= quo;
        done_q <= 1'b1;
      end else if (accept) begin
        unique case (1'b1)
          is_mul: begin
            {hi_q, lo_q} <= prod_s;
            done_q       <= 1'b1;
          end
          is_mulu: begin
            {hi_q, lo_q} <= prod_u;
            done_q       <= 1'b1;
          end
          is_mthi: hi_q <= md.a;
          is_mtlo: lo_q <= md.a;
          default: ;
        endcase
      end
    end
  end

  assign md.busy = (state != DS_IDLE);
  assign md.done = done_q;
  assign md.hi   = hi_q;
  assign md.lo   = lo_q;

endmodule
